// File: rtl/jt900h_shift_seq_pkg.sv
// Shared constants for the TLCS-900H shift/rotate sequencer: ALU op codes,
// carry-in source codes, shift-kind codes and the result width mask.
package jt900h_shift_seq_pkg;

    localparam logic [4:0] SHL_ALU = 5'd12;
    localparam logic [4:0] SHR_ALU = 5'd13;

    // ZERO_CX selects a constant 0 as the shifted-in bit
    localparam logic [2:0] ZERO_CX = 3'd0;
    localparam logic [2:0] CIN_CX  = 3'd1;
    localparam logic [2:0] SA_CX   = 3'd2;
    localparam logic [2:0] SH_CX   = 3'd3;

    localparam logic [2:0] SLA_K = 3'd0;
    localparam logic [2:0] SRA_K = 3'd1;
    localparam logic [2:0] SLL_K = 3'd2;
    localparam logic [2:0] SRL_K = 3'd3;
    localparam logic [2:0] RLC_K = 3'd4;
    localparam logic [2:0] RRC_K = 3'd5;
    localparam logic [2:0] RL_K  = 3'd6;
    localparam logic [2:0] RR_K  = 3'd7;

    function automatic logic [31:0] mask_width(
        input logic [31:0] v,
        input logic        bs,
        input logic        ws,
        input logic        qs
    );
        logic [31:0] r;
        if (qs) begin
            r = v;
        end else if (ws) begin
            r = {16'd0, v[15:0]};
        end else if (bs) begin
            r = {24'd0, v[7:0]};
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/jt900h_shift_seq.sv
// Multi-cycle shift/rotate sequencer driving the ALU one bit per cen cycle.
// Optional abort input enabled by defining JT900H_SHIFT_ABORT_EN.
module jt900h_shift_seq
    import jt900h_shift_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic        start,
`ifdef JT900H_SHIFT_ABORT_EN
    input  logic        abort,
`endif
    input  logic [2:0]  kind,
    input  logic        bs,
    input  logic        ws,
    input  logic        qs,
    input  logic [3:0]  cnt,
    input  logic [31:0] val,
    input  logic        cin,
    input  logic [31:0] alu_rslt,
    input  logic        alu_c,
    output logic [4:0]  alu_sel,
    output logic [2:0]  cx_sel,
    output logic [31:0] op2,
    output logic        alu_cin,
    output logic        busy,
    output logic        done,
    output logic [31:0] rslt,
    output logic        c
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]  state_r;
    logic [2:0]  kind_r;
    logic        bs_r;
    logic        ws_r;
    logic        qs_r;
    logic [31:0] acc_r;
    logic        carry_r;
    logic [4:0]  rem_r;
    logic        busy_r;
    logic        done_r;
    logic [31:0] rslt_r;
    logic        c_r;

    logic [4:0]  alu_sel_s;
    logic [2:0]  cx_sel_s;
    logic        abort_s;

`ifdef JT900H_SHIFT_ABORT_EN
    assign abort_s = abort;
`else
    assign abort_s = 1'b0;
`endif

    // Sequencer FSM, step counter, accumulator and completion registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            kind_r  <= 3'd0;
            bs_r    <= 1'b0;
            ws_r    <= 1'b0;
            qs_r    <= 1'b0;
            acc_r   <= 32'd0;
            carry_r <= 1'b0;
            rem_r   <= 5'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            rslt_r  <= 32'd0;
            c_r     <= 1'b0;
        end else begin
            // done is a single clk pulse, independent of cen
            done_r <= 1'b0;
            if (cen) begin
                case (state_r)
                    IDLE: begin
                        if (start) begin
                            state_r <= RUN;
                            kind_r  <= kind;
                            bs_r    <= bs;
                            ws_r    <= ws;
                            qs_r    <= qs;
                            acc_r   <= val;
                            carry_r <= cin;
                            rem_r   <= (cnt == 4'd0) ? 5'd16 : {1'b0, cnt};
                            busy_r  <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (abort_s) begin
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                        end else begin
                            acc_r   <= alu_rslt;
                            carry_r <= alu_c;
                            rem_r   <= rem_r - 5'd1;
                            if (rem_r == 5'd1) begin
                                state_r <= IDLE;
                                busy_r  <= 1'b0;
                                done_r  <= 1'b1;
                                rslt_r  <= mask_width(alu_rslt, bs_r, ws_r, qs_r);
                                c_r     <= alu_c;
                            end
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Per-step ALU operation and shifted-in bit source for the latched kind
    always_comb begin
        alu_sel_s = SHL_ALU;
        cx_sel_s  = ZERO_CX;
        if (state_r == RUN) begin
            case (kind_r)
                SLA_K:   begin alu_sel_s = SHL_ALU; cx_sel_s = ZERO_CX; end
                SLL_K:   begin alu_sel_s = SHL_ALU; cx_sel_s = ZERO_CX; end
                SRL_K:   begin alu_sel_s = SHR_ALU; cx_sel_s = ZERO_CX; end
                SRA_K:   begin alu_sel_s = SHR_ALU; cx_sel_s = SA_CX;   end
                RLC_K:   begin alu_sel_s = SHL_ALU; cx_sel_s = SA_CX;   end
                RRC_K:   begin alu_sel_s = SHR_ALU; cx_sel_s = SH_CX;   end
                RL_K:    begin alu_sel_s = SHL_ALU; cx_sel_s = CIN_CX;  end
                RR_K:    begin alu_sel_s = SHR_ALU; cx_sel_s = CIN_CX;  end
                default: begin alu_sel_s = SHL_ALU; cx_sel_s = ZERO_CX; end
            endcase
        end else begin
            alu_sel_s = SHL_ALU;
            cx_sel_s  = ZERO_CX;
        end
    end

    assign alu_sel = alu_sel_s;
    assign cx_sel  = cx_sel_s;
    assign op2     = acc_r;
    assign alu_cin = carry_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign rslt    = rslt_r;
    assign c       = c_r;

endmodule

// File: tb/tb_jt900h_shift_seq.sv
// Bench for jt900h_shift_seq: a behavioural one-bit ALU closes the loop and
// results are compared with a value-level shift/rotate reference model.
module tb_jt900h_shift_seq;
    import jt900h_shift_seq_pkg::*;

    logic        clk;
    logic        rst;
    logic        cen;
    logic        start;
    logic        abort;
    logic [2:0]  kind;
    logic        bs, ws, qs;
    logic [3:0]  cnt;
    logic [31:0] val;
    logic        cin;
    logic [31:0] alu_rslt;
    logic        alu_c;
    logic [4:0]  alu_sel;
    logic [2:0]  cx_sel;
    logic [31:0] op2;
    logic        alu_cin;
    logic        busy;
    logic        done;
    logic [31:0] rslt;
    logic        c;

    int n_checks = 0;
    int n_errs   = 0;
    int cur_w    = 8;

    jt900h_shift_seq dut (
        .clk(clk), .rst(rst), .cen(cen), .start(start),
`ifdef JT900H_SHIFT_ABORT_EN
        .abort(abort),
`endif
        .kind(kind), .bs(bs), .ws(ws), .qs(qs), .cnt(cnt), .val(val), .cin(cin),
        .alu_rslt(alu_rslt), .alu_c(alu_c), .alu_sel(alu_sel), .cx_sel(cx_sel),
        .op2(op2), .alu_cin(alu_cin), .busy(busy), .done(done), .rslt(rslt), .c(c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural one-bit ALU: SHL/SHR over the active width with selectable fill bit
    logic        alu_msb;
    logic        alu_fill;
    logic [31:0] alu_tmp;
    always_comb begin
        alu_msb = op2[cur_w-1];
        case (cx_sel)
            ZERO_CX: alu_fill = 1'b0;
            SA_CX:   alu_fill = alu_msb;
            SH_CX:   alu_fill = op2[0];
            CIN_CX:  alu_fill = alu_cin;
            default: alu_fill = 1'b0;
        endcase
        alu_tmp = {1'b0, op2[31:1]};
        alu_tmp[cur_w-1] = alu_fill;
        if (alu_sel == SHL_ALU) begin
            alu_rslt = {op2[30:0], alu_fill};
            alu_c    = alu_msb;
        end else begin
            alu_rslt = alu_tmp;
            alu_c    = op2[0];
        end
    end

    // Reference: apply the instruction's shift/rotate rule n times at value level
    task automatic ref_shift(input logic [2:0] k, input int w, input logic [31:0] v,
                             input logic [3:0] n, input logic ci,
                             output logic [31:0] r, output logic co);
        logic [63:0] m, x, top;
        logic cy, nc;
        int eff;
        eff = (n == 4'd0) ? 16 : int'(n);
        m   = (64'd1 << w) - 64'd1;
        top = 64'd1 << (w - 1);
        x   = {32'd0, v} & m;
        cy  = ci;
        for (int i = 0; i < eff; i++) begin
            case (k)
                SLA_K, SLL_K: begin cy = x[w-1]; x = (x << 1) & m; end
                SRA_K:        begin cy = x[0]; x = (x >> 1) | (x & top); end
                SRL_K:        begin cy = x[0]; x = x >> 1; end
                RLC_K:        begin cy = x[w-1]; x = ((x << 1) | {63'd0, cy}) & m; end
                RRC_K:        begin cy = x[0]; x = (x >> 1) | (cy ? top : 64'd0); end
                RL_K:         begin nc = x[w-1]; x = ((x << 1) | {63'd0, cy}) & m; cy = nc; end
                default:      begin nc = x[0]; x = (x >> 1) | (cy ? top : 64'd0); cy = nc; end
            endcase
        end
        r  = x[31:0];
        co = cy;
    endtask

    task automatic set_width(input int wsel);
        bs = (wsel == 0); ws = (wsel == 1); qs = (wsel == 2);
        cur_w = (wsel == 0) ? 8 : (wsel == 1) ? 16 : 32;
    endtask

    task automatic test_reset();
        rst = 1'b0; cen = 1'b1; start = 1'b0; abort = 1'b0;
        kind = 3'd0; cnt = 4'd0; val = 32'd0; cin = 1'b0; set_width(0);
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({busy, done, c} !== 3'b000 || rslt !== 32'd0 || op2 !== 32'd0 || alu_sel !== SHL_ALU) begin
            n_errs++;
            $display("FAIL reset: busy=%b done=%b c=%b rslt=%h op2=%h sel=%0d, required 0/0/0/0/0/%0d",
                     busy, done, c, rslt, op2, alu_sel, SHL_ALU);
        end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    // One full operation; called right after posedge+1
    task automatic do_op(input string name, input logic [2:0] k, input int wsel,
                         input logic [31:0] v, input logic [3:0] n, input logic ci,
                         input bit toggle, input bit poke);
        logic [31:0] er;
        logic ec;
        int eff, steps, clks;
        bit seen;
        eff = (n == 4'd0) ? 16 : int'(n);
        ref_shift(k, (wsel == 0) ? 8 : (wsel == 1) ? 16 : 32, v, n, ci, er, ec);
        kind = k; set_width(wsel); val = v; cnt = n; cin = ci; start = 1'b1; cen = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b1) begin
            n_errs++;
            $display("FAIL %s accept: busy=%b, required 1", name, busy);
        end
        start = 1'b0;
        // operand inputs are don't-care once accepted
        val = $urandom; cnt = 4'($urandom); cin = 1'($urandom); kind = 3'($urandom);
        steps = 0; clks = 0; seen = 0;
        for (int i = 0; i < 100; i++) begin
            cen   = toggle ? ((i % 2) == 1) : 1'b1;
            start = (poke && i == 1);
            @(posedge clk); #1;
            clks++;
            if (cen) steps++;
            if (done) begin
                seen = 1;
                break;
            end
        end
        start = 1'b0;
        n_checks++;
        if (!seen) begin
            n_errs++;
            $display("FAIL %s timeout: no done after %0d clks, required %0d steps", name, clks, eff);
        end
        n_checks++;
        if (steps !== eff || (toggle && clks !== 2 * eff) || busy !== 1'b0) begin
            n_errs++;
            $display("FAIL %s latency: steps=%0d clks=%0d busy=%b, required steps=%0d busy=0",
                     name, steps, clks, busy, eff);
        end
        n_checks++;
        if (rslt !== er || c !== ec) begin
            n_errs++;
            $display("FAIL %s result: rslt=%h c=%b, required rslt=%h c=%b", name, rslt, c, er, ec);
        end
        cen = toggle ? 1'b0 : 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_errs++;
            $display("FAIL %s done_clear: done=%b busy=%b, required 0/0", name, done, busy);
        end
        cen = 1'b1;
    endtask

    task automatic test_plan();
        do_op("sll_byte",  SLL_K, 0, 32'h00000081, 4'd1, 1'b0, 0, 0);
        do_op("rrc_word",  RRC_K, 1, 32'h00000001, 4'd4, 1'b0, 0, 0);
        do_op("sra_long",  SRA_K, 2, 32'h80000000, 4'd0, 1'b0, 0, 0);
        do_op("rl_byte",   RL_K,  0, 32'h00000080, 4'd2, 1'b0, 0, 0);
        do_op("sla_cen",   SLA_K, 1, 32'h00004000, 4'd2, 1'b0, 1, 1);
        do_op("rr_cin",    RR_K,  0, 32'hFFFFFF01, 4'd3, 1'b1, 0, 0);
    endtask

    task automatic test_reset_midrun();
        kind = SRL_K; set_width(2); val = 32'hF0F0_1234; cnt = 4'd8; cin = 1'b0;
        start = 1'b1; cen = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_errs++;
            $display("FAIL reset_midrun: busy=%b done=%b, required 0/0", busy, done);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        do_op("after_reset", SRL_K, 2, 32'hF0F0_1234, 4'd8, 1'b0, 0, 0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] er;
        logic ec;
        bit seen;
        ref_shift(RLC_K, 16, 32'h0000_8001, 4'd3, 1'b0, er, ec);
        kind = SLL_K; set_width(0); val = 32'h0000_0033; cnt = 4'd2; cin = 1'b0;
        start = 1'b1; cen = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done) begin seen = 1; break; end
        end
        kind = RLC_K; set_width(1); val = 32'h0000_8001; cnt = 4'd3;
        @(posedge clk); #1;
        n_checks++;
        if (!seen || busy !== 1'b1) begin
            n_errs++;
            $display("FAIL b2b_accept: seen_done=%b busy=%b, required 1/1", seen, busy);
        end
        start = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done) begin seen = 1; break; end
        end
        n_checks++;
        if (!seen || rslt !== er || c !== ec) begin
            n_errs++;
            $display("FAIL b2b_result: done=%b rslt=%h c=%b, required 1 %h %b", seen, rslt, c, er, ec);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            do_op("random", 3'($urandom_range(0, 7)), int'($urandom_range(0, 2)), $urandom,
                  4'($urandom_range(0, 15)), 1'($urandom), bit'($urandom_range(0, 1)), 0);
        end
    endtask

    initial begin
        test_reset();
        test_plan();
        test_reset_midrun();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
